// File: rtl/tx_word_sender.sv
// tx_word_sender: splits a word into N_DATA-bit bytes and feeds them to a UART transmitter.
// Ports: clock/reset (sync, active-high); word_in/word_valid/word_ready word handshake;
// tx_start/tx_data/read_tx/tx_done_tick transmitter protocol; busy, word_sent and
// timeout_err status (word_sent/timeout_err are one-cycle pulses on the first IDLE cycle).
module tx_word_sender #(
  parameter int NB_WORD     = 32,
  parameter int N_DATA      = 8,
  parameter int MSB_FIRST   = 0,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NB_WORD-1:0] word_in,
  input  logic               word_valid,
  output logic               word_ready,
  output logic               tx_start,
  output logic [N_DATA-1:0]  tx_data,
  input  logic               read_tx,
  input  logic               tx_done_tick,
  output logic               busy,
  output logic               word_sent,
  output logic               timeout_err
);
  localparam int N_BYTES = NB_WORD / N_DATA;
  localparam int BW = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [BW-1:0] LAST = BW'(N_BYTES - 1);
  localparam logic [TW-1:0] TLIM = TW'(ACK_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [NB_WORD-1:0] sreg_q, sreg_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic word_sent_q, word_sent_d, timeout_err_q, timeout_err_d;
  assign word_ready  = (state_q == IDLE) && !reset;
  assign busy        = state_q != IDLE;
  assign tx_start    = state_q == REQ;
  assign tx_data     = MSB_FIRST != 0 ? sreg_q[NB_WORD-1 -: N_DATA] : sreg_q[N_DATA-1:0];
  assign word_sent   = word_sent_q;
  assign timeout_err = timeout_err_q;
  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    cnt_d         = cnt_q;
    tcnt_d        = '0;
    word_sent_d   = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: if (word_valid && word_ready) begin
        state_d = REQ;
        sreg_d  = word_in;
        cnt_d   = '0;
      end
      REQ: if (read_tx) state_d = WAIT_DONE;
        else if (tcnt_q == TLIM) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else tcnt_d = tcnt_q + TW'(1);
      WAIT_DONE: if (tx_done_tick) begin
        if (cnt_q == LAST) begin
          state_d     = IDLE;
          word_sent_d = 1'b1;
        end else begin
          // move the next byte into the position tx_data reads from
          state_d = REQ;
          sreg_d  = MSB_FIRST != 0 ? sreg_q << N_DATA : sreg_q >> N_DATA;
          cnt_d   = cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      sreg_q        <= '0;
      cnt_q         <= '0;
      tcnt_q        <= '0;
      word_sent_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      cnt_q         <= cnt_d;
      tcnt_q        <= tcnt_d;
      word_sent_q   <= word_sent_d;
      timeout_err_q <= timeout_err_d;
    end
  end
endmodule

// File: tb/tb_tx_word_sender.sv
// tb_tx_word_sender: randomized self-checking bench with a behavioural transmitter and byte-order model.
module tb_tx_word_sender;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [31:0] word_in = '0;
  logic word_valid = 1'b0, sel = 1'b0;
  logic rsp_read = 1'b0, rsp_done = 1'b0, spur_read = 1'b0, spur_done = 1'b0;
  logic ts0, ts1, busy0, busy1, ws0, ws1, te0, te1, rdy0, rdy1;
  logic [7:0] d0, d1;
  logic m_ts, m_busy, m_ws, m_te, m_rdy;
  logic [7:0] m_data;
  assign m_ts   = sel ? ts1 : ts0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_ws   = sel ? ws1 : ws0;
  assign m_te   = sel ? te1 : te0;
  assign m_rdy  = sel ? rdy1 : rdy0;
  assign m_data = sel ? d1 : d0;
  tx_word_sender #(.NB_WORD(32), .N_DATA(8), .MSB_FIRST(0), .ACK_TIMEOUT(8)) dut0 (
    .clock(clk), .reset(rst), .word_in(word_in), .word_valid(word_valid && !sel),
    .word_ready(rdy0), .tx_start(ts0), .tx_data(d0),
    .read_tx((rsp_read || spur_read) && !sel), .tx_done_tick((rsp_done || spur_done) && !sel),
    .busy(busy0), .word_sent(ws0), .timeout_err(te0));
  tx_word_sender #(.NB_WORD(32), .N_DATA(8), .MSB_FIRST(1)) dut1 (
    .clock(clk), .reset(rst), .word_in(word_in), .word_valid(word_valid && sel),
    .word_ready(rdy1), .tx_start(ts1), .tx_data(d1),
    .read_tx((rsp_read || spur_read) && sel), .tx_done_tick((rsp_done || spur_done) && sel),
    .busy(busy1), .word_sent(ws1), .timeout_err(te1));
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, lat = 1, dly = 0, wcnt = 0, dcnt = 0, ts_run = 0, to_run = 0, ws_cnt = 0, te_cnt = 0;
  bit waiting = 0, inflight = 0, prev_ts = 0, stab = 0;
  logic [7:0] first_data = '0;
  logic [7:0] got[$];
  int tsc[$], ws_bytes[$], ws_cyc[$], rise_cyc[$];
  bit stable[$];
  // transmitter model + monitor: sees tx_start, answers read_tx lat cycles later, done after dly
  initial forever begin
    @(negedge clk);
    cyc++;
    rsp_read = 1'b0;
    rsp_done = 1'b0;
    if (rst) begin
      waiting = 0; inflight = 0; dcnt = 0; ts_run = 0; prev_ts = 0;
    end else begin
      if (m_ws) begin ws_cnt++; ws_bytes.push_back(got.size()); ws_cyc.push_back(cyc); end
      if (m_te) te_cnt++;
      if (m_ts && !prev_ts) rise_cyc.push_back(cyc);
      prev_ts = m_ts;
      if (m_ts) ts_run++;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin rsp_done = 1'b1; inflight = 0; end
      end
      if (waiting && !m_ts) begin
        to_run = ts_run; ts_run = 0; waiting = 0; inflight = 0;
      end else if (waiting) begin
        wcnt++;
        stab = stab && (m_data === first_data);
        if (wcnt >= lat) begin
          rsp_read = 1'b1;
          got.push_back(m_data); stable.push_back(stab); tsc.push_back(ts_run);
          ts_run = 0; waiting = 0;
          dcnt = dly == 0 ? int'($urandom_range(1, 5)) : dly;
        end
      end else if (m_ts && !inflight) begin
        waiting = 1; inflight = 1; wcnt = 0; first_data = m_data; stab = 1;
      end
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i, input bit msb);
    return 8'(w >> (8 * (msb ? 3 - i : i)));
  endfunction
  task automatic clear_mon();
    got.delete(); tsc.delete(); stable.delete(); ws_bytes.delete(); ws_cyc.delete(); rise_cyc.delete();
    ws_cnt = 0; te_cnt = 0;
  endtask
  task automatic accept(input logic [31:0] w);
    @(negedge clk); #1;
    n_cmp++;
    if (m_rdy !== 1'b1) begin n_bad++; $display("FAIL accept_ready got=%b exp=1", m_rdy); end
    word_in = w; word_valid = 1'b1;
    @(negedge clk); #1;
    word_valid = 1'b0;
  endtask
  task automatic wait_events(input int nws, input int nte, input int budget, input string nm);
    int k = 0;
    while ((ws_cnt < nws || te_cnt < nte) && k < budget) begin @(negedge clk); #1; k++; end
    n_cmp++;
    if (ws_cnt < nws || te_cnt < nte) begin
      n_bad++;
      $display("FAIL %s wait_expired ws=%0d te=%0d exp ws=%0d te=%0d", nm, ws_cnt, te_cnt, nws, nte);
    end
  endtask
  task automatic check_word(input logic [31:0] w, input bit msb, input int base, input string nm);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got.size() <= base + i || got[base+i] !== exp_byte(w, i, msb)) begin
        n_bad++;
        $display("FAIL %s byte%0d got=%h exp=%h", nm, i, got.size() > base + i ? got[base+i] : 8'hxx, exp_byte(w, i, msb));
      end else begin
        n_cmp++;
        if (tsc[base+i] != lat + 1 || !stable[base+i]) begin
          n_bad++;
          $display("FAIL %s req%0d tx_start_cycles=%0d exp=%0d stable=%0b", nm, i, tsc[base+i], lat + 1, stable[base+i]);
        end
      end
    end
  endtask
  task automatic run_word(input logic [31:0] w, input bit msb, input string nm);
    sel = msb;
    clear_mon();
    accept(w);
    wait_events(1, 0, 400, nm);
    n_cmp++;
    if ({m_busy, m_rdy, m_ws} !== 3'b011) begin
      n_bad++; $display("FAIL %s done_state busy/rdy/sent got=%b exp=011", nm, {m_busy, m_rdy, m_ws});
    end
    n_cmp++;
    if (got.size() != 4 || te_cnt != 0) begin
      n_bad++; $display("FAIL %s counts bytes=%0d te=%0d exp bytes=4 te=0", nm, got.size(), te_cnt);
    end
    check_word(w, msb, 0, nm);
    @(negedge clk); #1;
    n_cmp++;
    if (m_ws !== 1'b0) begin n_bad++; $display("FAIL %s sent_pulse_width got=%b exp=0", nm, m_ws); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({ts0, busy0, ws0, te0, rdy0, d0} !== 13'b0) begin
      n_bad++; $display("FAIL reset_dut0 got=%b exp=0", {ts0, busy0, ws0, te0, rdy0, d0});
    end
    n_cmp++;
    if ({ts1, busy1, ws1, te1, rdy1, d1} !== 13'b0) begin
      n_bad++; $display("FAIL reset_dut1 got=%b exp=0", {ts1, busy1, ws1, te1, rdy1, d1});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({rdy0, rdy1} !== 2'b11) begin n_bad++; $display("FAIL reset_ready got=%b exp=11", {rdy0, rdy1}); end
  endtask
  task automatic test_lsb_first();
    run_word(32'h11223344, 0, "lsb_fixed");
    repeat (4) run_word($urandom, 0, "lsb_rand");
  endtask
  task automatic test_msb_first();
    run_word(32'h11223344, 1, "msb_fixed");
    repeat (3) run_word($urandom, 1, "msb_rand");
  endtask
  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    int k = 0;
    w1 = 32'hAABBCCDD; w2 = 32'h01020304;
    sel = 0;
    clear_mon();
    @(negedge clk); #1;
    word_in = w1; word_valid = 1'b1;
    @(negedge clk); #1;
    word_in = w2;
    while (ws_cnt < 1 && k < 400) begin @(negedge clk); #1; k++; end
    @(negedge clk); #1;
    word_valid = 1'b0;
    wait_events(2, 0, 400, "b2b");
    n_cmp++;
    if (got.size() != 8 || ws_bytes.size() != 2) begin
      n_bad++; $display("FAIL b2b counts bytes=%0d sent=%0d exp 8/2", got.size(), ws_bytes.size());
    end else begin
      check_word(w1, 0, 0, "b2b_w1");
      check_word(w2, 0, 4, "b2b_w2");
      n_cmp++;
      if (ws_bytes[0] != 4 || ws_bytes[1] != 8) begin
        n_bad++; $display("FAIL b2b sent_spacing got=%0d,%0d exp=4,8", ws_bytes[0], ws_bytes[1]);
      end
      n_cmp++;
      if (rise_cyc.size() < 5 || rise_cyc[4] != ws_cyc[0] + 1) begin
        n_bad++;
        $display("FAIL b2b restart_gap rise=%0d exp=%0d", rise_cyc.size() >= 5 ? rise_cyc[4] : -1, ws_cyc[0] + 1);
      end
    end
  endtask
  task automatic test_timeout();
    sel = 0;
    lat = 100;
    clear_mon();
    accept($urandom);
    wait_events(0, 1, 60, "timeout");
    n_cmp++;
    if (to_run != 8) begin n_bad++; $display("FAIL timeout req_cycles got=%0d exp=8", to_run); end
    n_cmp++;
    if ({m_te, m_rdy, m_busy, m_ts} !== 4'b1100) begin
      n_bad++; $display("FAIL timeout state te/rdy/busy/start got=%b exp=1100", {m_te, m_rdy, m_busy, m_ts});
    end
    @(negedge clk); #1;
    n_cmp++;
    if (m_te !== 1'b0 || ws_cnt != 0 || got.size() != 0) begin
      n_bad++; $display("FAIL timeout after te=%b sent=%0d bytes=%0d exp 0/0/0", m_te, ws_cnt, got.size());
    end
    lat = 7;
    run_word($urandom, 0, "ack_at_limit");
    lat = 1;
  endtask
  task automatic test_reset_mid();
    int k = 0;
    sel = 0;
    dly = 5;
    clear_mon();
    accept($urandom);
    while (!(got.size() >= 3 && !m_ts && m_busy) && k < 100) begin @(negedge clk); #1; k++; end
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({m_ts, m_busy, m_rdy, m_ws, m_te} !== 5'b0) begin
      n_bad++; $display("FAIL rstmid in_reset got=%b exp=00000", {m_ts, m_busy, m_rdy, m_ws, m_te});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (m_rdy !== 1'b1 || ws_cnt != 0 || te_cnt != 0) begin
      n_bad++; $display("FAIL rstmid after rdy=%b sent=%0d te=%0d exp 1/0/0", m_rdy, ws_cnt, te_cnt);
    end
    dly = 0;
    repeat (3) @(negedge clk);
    run_word(32'h55667788, 0, "after_reset");
  endtask
  task automatic test_spurious();
    logic [31:0] w;
    sel = 0;
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      spur_read = 1'($urandom); spur_done = 1'($urandom);
      @(negedge clk); #1;
      n_cmp++;
      if ({m_busy, m_ts} !== 2'b00) begin n_bad++; $display("FAIL spur_idle%0d busy/start got=%b exp=00", i, {m_busy, m_ts}); end
    end
    spur_read = 1'b0; spur_done = 1'b0;
    w = $urandom;
    clear_mon();
    accept(w);
    for (int k = 0; ws_cnt < 1 && k < 400; k++) begin
      @(negedge clk); #1;
      word_valid = got.size() < 3 ? 1'($urandom) : 1'b0;
      word_in = $urandom;
    end
    word_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    n_cmp++;
    if (got.size() != 4 || ws_cnt != 1 || m_busy !== 1'b0) begin
      n_bad++; $display("FAIL spur_toggle bytes=%0d sent=%0d busy=%b exp 4/1/0", got.size(), ws_cnt, m_busy);
    end
    check_word(w, 0, 0, "spur_word");
  endtask
  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
